// File: rtl/door_controller.sv
// Elevator door sequencer: timed open/dwell/close cycle with obstruction and
// overload reopen, reporting when the car is sealed and when a cycle completes.
module door_controller #(
    parameter int MOVE_CYCLES  = 4,
    parameter int DWELL_CYCLES = 10,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic arrive_req,
    input  logic open_btn,
    input  logic close_btn,
    input  logic obstruction,
    input  logic weight_limit_exceeded,
    output logic motor_open,
    output logic motor_close,
    output logic door_closed,
    output logic overweight_alarm,
    output logic cycle_done
);

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MOVE_LAST  = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             hold;

    // The same condition holds the door open and reverses a closing door.
    assign hold = weight_limit_exceeded | obstruction | open_btn;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLOSED;
            cnt        <= '0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            case (state)
                CLOSED: begin
                    if (arrive_req | open_btn) begin
                        state <= OPENING;
                        cnt   <= MOVE_LAST;
                    end
                end
                OPENING: begin
                    if (cnt == '0) begin
                        state <= OPEN;
                        cnt   <= DWELL_LAST;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                OPEN: begin
                    if (hold) begin
                        cnt <= DWELL_LAST;
                    end else if (close_btn || cnt == '0) begin
                        state <= CLOSING;
                        cnt   <= MOVE_LAST;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CLOSING: begin
                    if (hold) begin
                        // Travel back only as far as the door has already closed.
                        state <= OPENING;
                        cnt   <= MOVE_LAST - cnt;
                    end else if (cnt == '0) begin
                        state      <= CLOSED;
                        cycle_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= CLOSED;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign door_closed      = (state == CLOSED);
    assign motor_open       = (state == OPENING);
    assign motor_close      = (state == CLOSING);
    assign overweight_alarm = weight_limit_exceeded & (state != CLOSED);

endmodule
